// File: rtl/fpu_wb_pkg.sv
// Shared types and constants for the FPU writeback stage.
package fpu_wb_pkg;
    localparam int WB_XLEN = 32;
    localparam int WB_FLEN = 16;
    localparam int WB_AW   = 5;

    // Bit positions inside the {NV,DZ,OF,UF,NX} exception flag vector
    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    localparam logic [WB_AW-1:0] REG_X0 = '0;

    typedef struct packed {
        logic [WB_AW-1:0]   addr;
        logic [WB_XLEN-1:0] data;
    } gpr_wr_t;
endpackage

// File: rtl/fpu_writeback_if.sv
// Result/write-port bundle between execute, the writeback stage and the register files.
interface fpu_writeback_if #(
    parameter int XLEN = 32,
    parameter int FLEN = 16,
    parameter int AW   = 5
);
    logic            alu_valid;
    logic [AW-1:0]   alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            fint_valid;
    logic [AW-1:0]   fint_rd;
    logic [XLEN-1:0] fint_data;
    logic            ffp_valid;
    logic [AW-1:0]   ffp_rd;
    logic [FLEN-1:0] ffp_data;
    logic [4:0]      sflags;
    logic            iv_exception;
    logic            fflags_clr;
    logic            gpr_we;
    logic [AW-1:0]   gpr_waddr;
    logic [XLEN-1:0] gpr_wdata;
    logic            fpr_we;
    logic [AW-1:0]   fpr_waddr;
    logic [FLEN-1:0] fpr_wdata;
    logic [4:0]      fflags;
    logic            iv_trap;
    logic            wb_busy;
    logic            ovf_err;

    modport master (
        output alu_valid, alu_rd, alu_data, fint_valid, fint_rd, fint_data,
               ffp_valid, ffp_rd, ffp_data, sflags, iv_exception, fflags_clr,
        input  gpr_we, gpr_waddr, gpr_wdata, fpr_we, fpr_waddr, fpr_wdata,
               fflags, iv_trap, wb_busy, ovf_err
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, fint_valid, fint_rd, fint_data,
               ffp_valid, ffp_rd, ffp_data, sflags, iv_exception, fflags_clr,
        output gpr_we, gpr_waddr, gpr_wdata, fpr_we, fpr_waddr, fpr_wdata,
               fflags, iv_trap, wb_busy, ovf_err
    );
endinterface

// File: rtl/fpu_wb_fifo.sv
// Conflict queue for GPR writes that lost arbitration; accepts up to two pushes per cycle.
module fpu_wb_fifo
    import fpu_wb_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push0,
    input  gpr_wr_t       i_push0_data,
    input  logic          i_push1,
    input  gpr_wr_t       i_push1_data,
    input  logic          i_pop,
    output gpr_wr_t       o_head,
    output logic [CW-1:0] o_count,
    output logic          o_ovf
);
    gpr_wr_t       r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;

    logic [CW-1:0] w_avail;
    logic [PW-1:0] w_wr_ptr1;
    logic          w_acc0;
    logic          w_acc1;
    logic          w_drop;

    // A pop in the same cycle frees a slot for an incoming push
    assign w_avail   = CW'(DEPTH) - r_count + CW'(i_pop);
    assign w_acc0    = i_push0 && (w_avail != '0);
    assign w_acc1    = i_push1 && (w_avail >= CW'(2));
    assign w_drop    = (i_push0 && !w_acc0) || (i_push1 && !w_acc1);
    assign w_wr_ptr1 = r_wr_ptr + PW'(1);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (w_acc0 && (r_wr_ptr == PW'(gi))) begin
                    r_mem[gi] <= i_push0_data;
                end else if (w_acc1 && (w_wr_ptr1 == PW'(gi))) begin
                    r_mem[gi] <= i_push1_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PW'(w_acc0) + PW'(w_acc1);
            r_rd_ptr <= r_rd_ptr + PW'(i_pop);
            r_count  <= r_count + CW'(w_acc0) + CW'(w_acc1) - CW'(i_pop);
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_ovf   = r_ovf;
endmodule

// File: rtl/fpu_writeback.sv
// Writeback stage: arbitrates the single GPR write port, forwards FP results, accumulates fflags.
module fpu_writeback
    import fpu_wb_pkg::*;
#(
    parameter int XLEN  = WB_XLEN,
    parameter int FLEN  = WB_FLEN,
    parameter int AW    = WB_AW,
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic      clk,
    input  logic      rst,
    fpu_writeback_if.slave wb
);
    logic            w_alu_c;
    logic            w_fint_c;
    logic            w_head_v;
    logic            w_win_v;
    gpr_wr_t         w_win;
    gpr_wr_t         w_head;
    gpr_wr_t         w_alu_req;
    gpr_wr_t         w_fint_req;
    gpr_wr_t         w_push0_data;
    logic            w_alu_push;
    logic            w_fint_push;
    logic            w_push0;
    logic            w_push1;
    logic [CW-1:0]   w_count;
    logic            w_ovf;
    logic            w_fpu_any;

    logic            r_gpr_we;
    logic [AW-1:0]   r_gpr_waddr;
    logic [XLEN-1:0] r_gpr_wdata;
    logic            r_fpr_we;
    logic [AW-1:0]   r_fpr_waddr;
    logic [FLEN-1:0] r_fpr_wdata;
    logic [4:0]      r_fflags;
    logic            r_iv_trap;

    // Writes to x0 are discarded before they can win or occupy the queue
    assign w_alu_c    = wb.alu_valid  && (wb.alu_rd  != REG_X0);
    assign w_fint_c   = wb.fint_valid && (wb.fint_rd != REG_X0);
    assign w_alu_req  = {wb.alu_rd, wb.alu_data};
    assign w_fint_req = {wb.fint_rd, wb.fint_data};
    assign w_head_v   = (w_count != '0);
    assign w_fpu_any  = wb.ffp_valid | wb.fint_valid;

    always_comb begin
        w_win_v     = 1'b1;
        w_win       = w_head;
        w_alu_push  = 1'b0;
        w_fint_push = 1'b0;
        if (w_head_v) begin
            w_alu_push  = w_alu_c;
            w_fint_push = w_fint_c;
        end else if (w_alu_c) begin
            w_win       = w_alu_req;
            w_fint_push = w_fint_c;
        end else if (w_fint_c) begin
            w_win = w_fint_req;
        end else begin
            w_win_v = 1'b0;
        end
    end

    // Compact the losers so the FIFO sees ALU ahead of FINT on its first port
    assign w_push0      = w_alu_push | w_fint_push;
    assign w_push1      = w_alu_push & w_fint_push;
    assign w_push0_data = w_alu_push ? w_alu_req : w_fint_req;

    fpu_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push0     (w_push0),
        .i_push0_data(w_push0_data),
        .i_push1     (w_push1),
        .i_push1_data(w_fint_req),
        .i_pop       (w_head_v),
        .o_head      (w_head),
        .o_count     (w_count),
        .o_ovf       (w_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gpr_we    <= 1'b0;
            r_gpr_waddr <= '0;
            r_gpr_wdata <= '0;
            r_fpr_we    <= 1'b0;
            r_fpr_waddr <= '0;
            r_fpr_wdata <= '0;
            r_fflags    <= '0;
            r_iv_trap   <= 1'b0;
        end else begin
            r_gpr_we <= w_win_v;
            if (w_win_v) begin
                r_gpr_waddr <= w_win.addr;
                r_gpr_wdata <= w_win.data;
            end
            r_fpr_we    <= wb.ffp_valid;
            r_fpr_waddr <= wb.ffp_rd;
            r_fpr_wdata <= wb.ffp_data;
            r_fflags    <= (wb.fflags_clr ? 5'd0 : r_fflags) | (w_fpu_any ? wb.sflags : 5'd0);
            r_iv_trap   <= wb.iv_exception & w_fpu_any;
        end
    end

    assign wb.gpr_we    = r_gpr_we;
    assign wb.gpr_waddr = r_gpr_waddr;
    assign wb.gpr_wdata = r_gpr_wdata;
    assign wb.fpr_we    = r_fpr_we;
    assign wb.fpr_waddr = r_fpr_waddr;
    assign wb.fpr_wdata = r_fpr_wdata;
    assign wb.fflags    = r_fflags;
    assign wb.iv_trap   = r_iv_trap;
    assign wb.wb_busy   = (w_count >= CW'(DEPTH - 1));
    assign wb.ovf_err   = w_ovf;
endmodule

// File: tb/tb_fpu_writeback.sv
// Directed bench for fpu_writeback: vector table plus conflict, overflow and reset sequences.
module tb_fpu_writeback;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    fpu_writeback_if #(.XLEN(32), .FLEN(16), .AW(5)) wb_if ();

    fpu_writeback #(.XLEN(32), .FLEN(16), .AW(5), .DEPTH(2)) dut (
        .clk(clk),
        .rst(rst),
        .wb (wb_if)
    );

    typedef struct {
        logic        alu_v;  logic [4:0] alu_rd;  logic [31:0] alu_d;
        logic        fint_v; logic [4:0] fint_rd; logic [31:0] fint_d;
        logic        ffp_v;  logic [4:0] ffp_rd;  logic [15:0] ffp_d;
        logic [4:0]  sfl;    logic iv;            logic clr;
        logic        e_gwe;  logic [4:0] e_gaddr; logic [31:0] e_gdata;
        logic        e_fwe;  logic [4:0] e_faddr; logic [15:0] e_fdata;
        logic [4:0]  e_ff;   logic e_trap;        logic e_busy;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s = 0x%0h", name, act);
        end
    endtask

    task automatic idle();
        wb_if.alu_valid = 0; wb_if.alu_rd = 0; wb_if.alu_data = 0;
        wb_if.fint_valid = 0; wb_if.fint_rd = 0; wb_if.fint_data = 0;
        wb_if.ffp_valid = 0; wb_if.ffp_rd = 0; wb_if.ffp_data = 0;
        wb_if.sflags = 0; wb_if.iv_exception = 0; wb_if.fflags_clr = 0;
    endtask

    task automatic apply(input vec_t v);
        wb_if.alu_valid = v.alu_v;   wb_if.alu_rd = v.alu_rd;   wb_if.alu_data = v.alu_d;
        wb_if.fint_valid = v.fint_v; wb_if.fint_rd = v.fint_rd; wb_if.fint_data = v.fint_d;
        wb_if.ffp_valid = v.ffp_v;   wb_if.ffp_rd = v.ffp_rd;   wb_if.ffp_data = v.ffp_d;
        wb_if.sflags = v.sfl; wb_if.iv_exception = v.iv; wb_if.fflags_clr = v.clr;
    endtask

    task automatic dual(input logic [4:0] ard, input logic [31:0] ad,
                        input logic [4:0] frd, input logic [31:0] fd);
        idle();
        wb_if.alu_valid = 1;  wb_if.alu_rd = ard;  wb_if.alu_data = ad;
        wb_if.fint_valid = 1; wb_if.fint_rd = frd; wb_if.fint_data = fd;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " gpr_we"},    32'(wb_if.gpr_we), 0);
        check({tag, " gpr_waddr"}, 32'(wb_if.gpr_waddr), 0);
        check({tag, " gpr_wdata"}, wb_if.gpr_wdata, 0);
        check({tag, " fpr_we"},    32'(wb_if.fpr_we), 0);
        check({tag, " fpr_waddr"}, 32'(wb_if.fpr_waddr), 0);
        check({tag, " fpr_wdata"}, 32'(wb_if.fpr_wdata), 0);
        check({tag, " fflags"},    32'(wb_if.fflags), 0);
        check({tag, " iv_trap"},   32'(wb_if.iv_trap), 0);
        check({tag, " wb_busy"},   32'(wb_if.wb_busy), 0);
        check({tag, " ovf_err"},   32'(wb_if.ovf_err), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0]  got_addr [$];
        logic [31:0] got_data [$];
        logic [4:0]  exp_addr [5];
        logic [31:0] exp_data [5];

        //            alu              fint             ffp                sfl      iv clr  gpr expected          fpr expected       ff     trap busy
        vecs[0] = '{1, 5,  32'h12345678, 0, 0, 0,     0, 0,  16'h0,    5'b00000, 0, 0, 1, 5,  32'h12345678, 0, 0,  16'h0,    5'h00, 0, 0};
        vecs[1] = '{0, 0,  0,            0, 0, 0,     0, 0,  16'h0,    5'b00000, 0, 0, 0, 5,  32'h12345678, 0, 0,  16'h0,    5'h00, 0, 0};
        vecs[2] = '{1, 0,  32'hFF,       1, 7, 1,     0, 0,  16'h0,    5'b00000, 0, 0, 1, 7,  32'h1,        0, 0,  16'h0,    5'h00, 0, 0};
        vecs[3] = '{0, 0,  0,            0, 0, 0,     1, 0,  16'hBEEF, 5'b00001, 0, 0, 0, 7,  32'h1,        1, 0,  16'hBEEF, 5'h01, 0, 0};
        vecs[4] = '{0, 0,  0,            1, 9, 32'h55,0, 0,  16'h0,    5'b10000, 1, 0, 1, 9,  32'h55,       0, 0,  16'h0,    5'h11, 1, 0};
        vecs[5] = '{0, 0,  0,            0, 0, 0,     0, 0,  16'h0,    5'b01000, 1, 0, 0, 9,  32'h55,       0, 0,  16'h0,    5'h11, 0, 0};
        vecs[6] = '{0, 0,  0,            0, 0, 0,     1, 3,  16'h1234, 5'b00100, 0, 1, 0, 9,  32'h55,       1, 3,  16'h1234, 5'h04, 0, 0};
        vecs[7] = '{0, 0,  0,            0, 0, 0,     0, 0,  16'h0,    5'b00000, 0, 1, 0, 9,  32'h55,       0, 0,  16'h0,    5'h00, 0, 0};
        vecs[8] = '{1, 31, 32'hDEADBEEF, 0, 0, 0,     1, 31, 16'hFFFF, 5'b00010, 0, 0, 1, 31, 32'hDEADBEEF, 1, 31, 16'hFFFF, 5'h02, 0, 0};
        vecs[9] = '{0, 0,  0,            1, 0, 32'h77,0, 0,  16'h0,    5'b01000, 0, 0, 0, 31, 32'hDEADBEEF, 0, 0,  16'h0,    5'h0A, 0, 0};

        idle();
        rst = 1;
        @(negedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst = 0;

        for (int i = 0; i < 10; i++) begin
            apply(vecs[i]);
            @(negedge clk);
            check($sformatf("vec%0d gpr_we", i),    32'(wb_if.gpr_we),    32'(vecs[i].e_gwe));
            check($sformatf("vec%0d gpr_waddr", i), 32'(wb_if.gpr_waddr), 32'(vecs[i].e_gaddr));
            check($sformatf("vec%0d gpr_wdata", i), wb_if.gpr_wdata,      vecs[i].e_gdata);
            check($sformatf("vec%0d fpr_we", i),    32'(wb_if.fpr_we),    32'(vecs[i].e_fwe));
            check($sformatf("vec%0d fpr_waddr", i), 32'(wb_if.fpr_waddr), 32'(vecs[i].e_faddr));
            check($sformatf("vec%0d fpr_wdata", i), 32'(wb_if.fpr_wdata), 32'(vecs[i].e_fdata));
            check($sformatf("vec%0d fflags", i),    32'(wb_if.fflags),    32'(vecs[i].e_ff));
            check($sformatf("vec%0d iv_trap", i),   32'(wb_if.iv_trap),   32'(vecs[i].e_trap));
            check($sformatf("vec%0d wb_busy", i),   32'(wb_if.wb_busy),   32'(vecs[i].e_busy));
        end

        // Conflict: ALU wins first, FINT drains from the queue a cycle later
        dual(5'd3, 32'hA, 5'd4, 32'hB);
        @(negedge clk);
        idle();
        check("conflict T+1 gpr_we",    32'(wb_if.gpr_we), 1);
        check("conflict T+1 gpr_waddr", 32'(wb_if.gpr_waddr), 3);
        check("conflict T+1 gpr_wdata", wb_if.gpr_wdata, 32'hA);
        check("conflict T+1 wb_busy",   32'(wb_if.wb_busy), 1);
        @(negedge clk);
        check("conflict T+2 gpr_we",    32'(wb_if.gpr_we), 1);
        check("conflict T+2 gpr_waddr", 32'(wb_if.gpr_waddr), 4);
        check("conflict T+2 gpr_wdata", wb_if.gpr_wdata, 32'hB);
        check("conflict T+2 wb_busy",   32'(wb_if.wb_busy), 0);
        @(negedge clk);
        check("conflict T+3 gpr_we",    32'(wb_if.gpr_we), 0);
        check("conflict ovf_err",       32'(wb_if.ovf_err), 0);

        // Overflow: three back-to-back dual issues, the third FINT is lost
        for (int i = 0; i < 5; i++) begin
            exp_addr[i] = (i % 2 == 0) ? 5'(1 + i / 2) : 5'(11 + i / 2);
            exp_data[i] = (i % 2 == 0) ? 32'(32'h101 + i / 2) : 32'(32'h111 + i / 2);
        end
        for (int i = 0; i < 8; i++) begin
            if (i < 3) dual(5'(1 + i), 32'(32'h101 + i), 5'(11 + i), 32'(32'h111 + i));
            else idle();
            @(negedge clk);
            if (wb_if.gpr_we) begin
                got_addr.push_back(wb_if.gpr_waddr);
                got_data.push_back(wb_if.gpr_wdata);
            end
            if (i == 1) check("overflow ovf_err before drop", 32'(wb_if.ovf_err), 0);
        end
        check("overflow ovf_err", 32'(wb_if.ovf_err), 1);
        check("overflow write count", 32'(got_addr.size()), 5);
        for (int i = 0; i < 5 && i < got_addr.size(); i++) begin
            check($sformatf("overflow write%0d addr", i), 32'(got_addr[i]), 32'(exp_addr[i]));
            check($sformatf("overflow write%0d data", i), got_data[i], exp_data[i]);
        end

        rst = 1;
        @(negedge clk);
        rst = 0;
        check("ovf_err cleared by reset", 32'(wb_if.ovf_err), 0);

        // Reset with two entries still queued: nothing may be written afterwards
        dual(5'd20, 32'hA0, 5'd21, 32'hA1);
        @(negedge clk);
        dual(5'd22, 32'hA2, 5'd23, 32'hA3);
        @(negedge clk);
        idle();
        check("midq busy before reset", 32'(wb_if.wb_busy), 1);
        check("midq write before reset", 32'(wb_if.gpr_waddr), 21);
        rst = 1;
        @(negedge clk);
        rst = 0;
        check_all_zero("midq after reset");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("midq idle%0d gpr_we", i), 32'(wb_if.gpr_we), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
